// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the FSM state encoding, the fetch queue entry layout and reset/step constants.
// Fixed-width types here match the default XLEN=64 / ILEN=32 build.
package imem_fetch_ctrl_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam int unsigned FQ_DEPTH_DEF = 4;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;
  localparam logic [XLEN_DEF-1:0] PC_STEP_DEF  = 64'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// Circular fetch queue: DEPTH entries of entry_t, push/pop/flush, occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: caller must not push when full without popping; flush beats push/pop.
module imem_fetch_ctrl_queue
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = FQ_DEPTH_DEF,
  parameter type         entry_t = fq_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  entry_t                     push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives IMEM one fetch/cycle into a queue for decode.
// Latency: fetch-to-decode 1 cycle; decode outputs come only from queue registers.
// Backpressure: fetch stalls when the queue is full and decode does not pop. FETCH_PERF_EN adds perf counters.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0],
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF[XLEN-1:0],
  parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [ILEN-1:0]  imem_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [XLEN-1:0]  dec_pc,
  output logic [ILEN-1:0]  dec_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_redirect_cnt,
  output logic [31:0]      perf_full_cnt
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  logic            pop;
  logic            push;
  logic            flush;
  logic            q_full;
  entry_t          head;
  entry_t          push_dat;

  assign q_full    = (count == CW'(FQ_DEPTH));
  assign dec_valid = (count != '0);
  assign pop       = dec_valid && dec_ready;
  // Redirects are dropped while booting so the reset PC is always fetched first.
  assign flush     = (state_q != BOOT) && redirect_valid;
  assign push      = (state_q == RUN) && !halt && !redirect_valid && (!q_full || pop);
  assign push_dat  = '{pc: pc_q, instr: imem_data};

  assign imem_en   = push;
  assign imem_addr = pc_q;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  // FSM next state: one idle boot cycle, then RUN/HALT follow the halt input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // PC next value: redirect target wins, otherwise step past each issued fetch.
  always_comb begin
    pc_d = pc_q;
    if (flush)     pc_d = redirect_pc;
    else if (push) pc_d = pc_q + PC_STEP;
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  imem_fetch_ctrl_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_o     (head),
    .count_o    (count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q, perf_full_q;
  logic        full_stall;

  assign full_stall = (state_q == RUN) && q_full && !pop;

  // Saturating event counters: fetches issued, accepted redirects, full-queue stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
      perf_full_q     <= '0;
    end else begin
      if (push && (perf_fetch_q != '1))          perf_fetch_q    <= perf_fetch_q + 32'd1;
      if (flush && (perf_redirect_q != '1))      perf_redirect_q <= perf_redirect_q + 32'd1;
      if (full_stall && (perf_full_q != '1))     perf_full_q     <= perf_full_q + 32'd1;
    end
  end

  assign perf_fetch_cnt    = perf_fetch_q;
  assign perf_redirect_cnt = perf_redirect_q;
  assign perf_full_cnt     = perf_full_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with an IMEM model returning 0x1000_0000 + addr.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Optional perf ports are connected when FETCH_PERF_EN is defined.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_full_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'h1000_0000 + imem_addr[31:0];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_full_cnt     (perf_full_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en;
    reset = 1'b1; dec_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick(); tick();
    #1;
    chk("rst_imem_en",   64'(imem_en),   64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_pc",    dec_pc,         64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_imem_addr", imem_addr,      64'd0);

    // 1: streaming from reset, decode always ready
    dec_ready = 1'b1; reset = 1'b0;
    #1; chk("s1_boot_no_fetch", 64'(imem_en), 64'd0);
    tick(); #1;
    chk("s1_first_valid_low", 64'(dec_valid), 64'd0);
    chk("s1_first_fetch",     64'(imem_en),   64'd1);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk("s1_valid", 64'(dec_valid), 64'd1);
      chk("s1_pc",    dec_pc,         64'(4 * k));
      chk("s1_instr", 64'(dec_instr), 64'(32'h1000_0000 + 32'(4 * k)));
    end

    // 2: decode stalled for 10 cycles after reset
    reset = 1'b1; tick();
    reset = 1'b0; dec_ready = 1'b0;
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (imem_en) n_en++;
      tick();
    end
    #1;
    chk("s2_en_pulses", 64'(n_en),    64'd4);
    chk("s2_pc",        imem_addr,    64'd16);
    chk("s2_en_low",    64'(imem_en), 64'd0);
`ifdef FETCH_PERF_EN
    chk("s2_perf_fetch", 64'(perf_fetch_cnt), 64'd4);
`endif
    dec_ready = 1'b1;
    #1; chk("s2_refetch_on_pop", 64'(imem_en), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("s2_valid", 64'(dec_valid), 64'd1);
      chk("s2_pc",    dec_pc,         64'(4 * k));
      tick(); #1;
    end

    // 3: redirect with three entries queued
    reset = 1'b1; tick();
    reset = 1'b0; dec_ready = 1'b0;
    tick(); tick(); tick(); tick();
    #1; chk("s3_pre_pc", imem_addr, 64'd12);
    chk("s3_pre_valid", 64'(dec_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    #1; chk("s3_no_push_on_redirect", 64'(imem_en), 64'd0);
    tick();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    #1;
    chk("s3_flushed",   64'(dec_valid), 64'd0);
    chk("s3_addr",      imem_addr,      64'h100);
    chk("s3_fetch",     64'(imem_en),   64'd1);
    tick(); #1;
    chk("s3_valid",     64'(dec_valid), 64'd1);
    chk("s3_pc",        dec_pc,         64'h100);
    chk("s3_instr",     64'(dec_instr), 64'h1000_0100);

    // 4: halt while streaming at pc=0x20
    redirect_valid = 1'b1; redirect_pc = 64'h18; dec_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    halt = 1'b1; dec_ready = 1'b1;
    #1;
    chk("s4_addr_at_halt", imem_addr,    64'h20);
    chk("s4_en_off",       64'(imem_en), 64'd0);
    chk("s4_head",         dec_pc,       64'h18);
    tick(); #1;
    chk("s4_drain_pc",     dec_pc,       64'h1C);
    chk("s4_en_off2",      64'(imem_en), 64'd0);
    tick(); #1;
    chk("s4_empty",        64'(dec_valid), 64'd0);
    tick();
    halt = 1'b0;
    #1; chk("s4_still_halted", 64'(imem_en), 64'd0);
    tick(); #1;
    chk("s4_resume_en",    64'(imem_en), 64'd1);
    chk("s4_resume_addr",  imem_addr,    64'h20);
    tick(); #1;
    chk("s4_resume_pc",    dec_pc,       64'h20);

    // 5: reset with the queue full
    dec_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("s5_full_valid", 64'(dec_valid), 64'd1);
    chk("s5_full_stall", 64'(imem_en),   64'd0);
    reset = 1'b1; tick();
    reset = 1'b0;
    #1;
    chk("s5_valid",     64'(dec_valid), 64'd0);
    chk("s5_addr",      imem_addr,      64'd0);
    chk("s5_boot_en",   64'(imem_en),   64'd0);
    chk("s5_dec_pc",    dec_pc,         64'd0);
    tick(); #1;
    chk("s5_run_en",    64'(imem_en),   64'd1);

    // 6: PC wrap at the top of the address space
    dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1; chk("s6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); #1;
    chk("s6_pc_top",    dec_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    chk("s6_instr_top", 64'(dec_instr), 64'h0FFF_FFFC);
    chk("s6_addr_wrap", imem_addr,      64'd0);
    tick(); #1;
    chk("s6_pc_wrap",    dec_pc,         64'd0);
    chk("s6_instr_wrap", 64'(dec_instr), 64'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
